// File: rtl/ucr_pkg.sv
// Shared definitions for the UCR4 counter and the sequencers that drive it:
// counter function select codes and the step-sequencer state encoding.
package ucr_pkg;

  typedef logic [1:0] ucr_sel_t;

  localparam ucr_sel_t UCR_LOAD = 2'b00;
  localparam ucr_sel_t UCR_DEC  = 2'b01;
  localparam ucr_sel_t UCR_INC  = 2'b10;
  localparam ucr_sel_t UCR_HOLD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FIRST = 2'd2,
    RUN   = 2'd3
  } ucr_seq_state_t;

endpackage

// File: rtl/ucr_step_seq.sv
// Control stage for a UCR4-style counter: loads COUNT, decrements once per
// cycle and reports completion on the counter's terminal borrow (N+1 steps).
module ucr_step_seq
  import ucr_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [W-1:0] COUNT,
  input  logic         HOLD_REQ,
  input  logic         ABORT,
  output logic         BUSY,
  output logic         STEP,
  output logic         DONE,
  output logic [W-1:0] UCR_D,
  output logic [1:0]   UCR_SEL,
  output logic         UCR_CIN,
  input  logic         UCR_COUT
);

  ucr_seq_state_t state_q, state_d;
  logic [W-1:0]   d_q, d_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    BUSY    = 1'b0;
    STEP    = 1'b0;
    DONE    = 1'b0;
    UCR_SEL = UCR_HOLD;
    UCR_CIN = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          d_d     = COUNT;
          state_d = LOAD;
        end
      end
      LOAD: begin
        BUSY    = 1'b1;
        UCR_SEL = UCR_LOAD;
        state_d = FIRST;
      end
      FIRST: begin
        // COUT still carries the 1 forced by LOAD, so it is not a borrow here
        BUSY = 1'b1;
        if (!HOLD_REQ) begin
          UCR_SEL = UCR_DEC;
          UCR_CIN = 1'b1;
          STEP    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        if (UCR_COUT) begin
          DONE    = 1'b1;
          state_d = IDLE;
        end else if (!HOLD_REQ) begin
          UCR_SEL = UCR_DEC;
          UCR_CIN = 1'b1;
          STEP    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; the counter is simply left holding.
    if (ABORT && state_q != IDLE) begin
      UCR_SEL = UCR_HOLD;
      UCR_CIN = 1'b0;
      STEP    = 1'b0;
      DONE    = 1'b0;
      state_d = IDLE;
    end
  end

  assign UCR_D = d_q;

endmodule

// File: tb/tb_ucr_step_seq.sv
// Bench for ucr_step_seq with a UCR4 counter model beside it, a step-count
// reference model compared every cycle, and directed timing scenarios.
module tb_ucr_step_seq;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [3:0] COUNT = 4'd0;
  logic       HOLD_REQ = 1'b0;
  logic       ABORT = 1'b0;
  logic       BUSY, STEP, DONE, UCR_CIN, UCR_COUT;
  logic [3:0] UCR_D;
  logic [1:0] UCR_SEL;

  int total = 0;
  int bad = 0;

  ucr_step_seq #(.W(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .COUNT(COUNT),
    .HOLD_REQ(HOLD_REQ), .ABORT(ABORT), .BUSY(BUSY), .STEP(STEP),
    .DONE(DONE), .UCR_D(UCR_D), .UCR_SEL(UCR_SEL), .UCR_CIN(UCR_CIN),
    .UCR_COUT(UCR_COUT)
  );

  always #5 CLK = ~CLK;

  // Counter model with the contract the sequencer relies on
  logic [3:0] cnt_q;
  logic       cnt_cout;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q    <= 4'd0;
      cnt_cout <= 1'b0;
    end else if (UCR_SEL == 2'b00) begin
      cnt_q    <= UCR_D;
      cnt_cout <= 1'b1;
    end else if (UCR_SEL == 2'b01 && UCR_CIN) begin
      cnt_q    <= cnt_q - 4'd1;
      cnt_cout <= (cnt_q == 4'd0);
    end
  end
  assign UCR_COUT = cnt_cout;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a load cycle, N+1 non-held step cycles,
  // then one done cycle; abort ends it at once.
  bit m_active = 0, m_load = 0;
  int m_left = 0;
  int m_d = 0;
  always @(negedge CLK) begin
    int e_busy, e_step, e_done, e_sel, e_cin, e_d;
    if (RESET) begin
      m_active = 0; m_load = 0; m_left = 0; m_d = 0;
    end else begin
      e_busy = 0; e_step = 0; e_done = 0; e_sel = 3; e_cin = 0; e_d = m_d;
      if (!m_active) begin
        if (START && !ABORT) begin
          m_active = 1; m_load = 1; m_left = int'(COUNT) + 1; m_d = int'(COUNT);
        end
      end else begin
        e_busy = 1;
        if (ABORT) m_active = 0;
        else if (m_load) begin e_sel = 0; m_load = 0; end
        else if (m_left == 0) begin e_done = 1; m_active = 0; end
        else if (!HOLD_REQ) begin e_step = 1; e_sel = 1; e_cin = 1; m_left--; end
      end
      chk("model_busy", int'(BUSY), e_busy);
      chk("model_step", int'(STEP), e_step);
      chk("model_done", int'(DONE), e_done);
      chk("model_sel", int'(UCR_SEL), e_sel);
      chk("model_cin", int'(UCR_CIN), e_cin);
      chk("model_d", int'(UCR_D), e_d);
    end
  end

  // Per-cycle trace of one directed sequence, cycle 0 = START cycle
  logic       tr_step[32], tr_done[32], tr_busy[32];
  logic [1:0] tr_sel[32];
  logic [3:0] tr_d[32];

  task automatic run_seq(input int n, input logic [31:0] hold_m,
                         input logic [31:0] abort_m, input int xs_at);
    logic [3:0] nv;
    nv = n[3:0];
    for (int k = 0; k < 26; k++) begin
      @(posedge CLK); #1;
      START    = (k == 0) || (k == xs_at);
      COUNT    = (k == 0) ? nv : 4'($urandom);
      HOLD_REQ = hold_m[k];
      ABORT    = abort_m[k];
      @(negedge CLK);
      tr_step[k] = STEP; tr_done[k] = DONE; tr_busy[k] = BUSY;
      tr_sel[k]  = UCR_SEL; tr_d[k] = UCR_D;
    end
    @(posedge CLK); #1;
    START = 0; HOLD_REQ = 0; ABORT = 0;
  endtask

  function automatic int n_steps();
    int c = 0;
    for (int k = 0; k < 26; k++) c += int'(tr_step[k]);
    return c;
  endfunction

  function automatic int done_cyc();
    for (int k = 0; k < 26; k++) if (tr_done[k]) return k;
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_step", int'(STEP), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_sel", int'(UCR_SEL), 3);
    chk("rst_cin", int'(UCR_CIN), 0);
    chk("rst_d", int'(UCR_D), 0);
    @(posedge CLK); #1 RESET = 0;

    run_seq(3, 32'h0, 32'h0, -1);
    $display("seq N=3: steps=%0d done@%0d", n_steps(), done_cyc());
    chk("n3_load_sel", int'(tr_sel[1]), 0);
    chk("n3_busy1", int'(tr_busy[1]), 1);
    chk("n3_busy0", int'(tr_busy[0]), 0);
    chk("n3_first_step", int'(tr_step[2]), 1);
    chk("n3_last_step", int'(tr_step[5]), 1);
    chk("n3_steps", n_steps(), 4);
    chk("n3_done", done_cyc(), 6);
    chk("n3_busy7", int'(tr_busy[7]), 0);
    chk("n3_cnt_q", int'(cnt_q), 15);

    run_seq(0, 32'h0, 32'h0, -1);
    $display("seq N=0: steps=%0d done@%0d", n_steps(), done_cyc());
    chk("n0_steps", n_steps(), 1);
    chk("n0_step2", int'(tr_step[2]), 1);
    chk("n0_done", done_cyc(), 3);

    run_seq(15, 32'h0, 32'h0, -1);
    $display("seq N=15: steps=%0d done@%0d", n_steps(), done_cyc());
    chk("n15_steps", n_steps(), 16);
    chk("n15_done", done_cyc(), 18);

    run_seq(2, 32'h14, 32'h0, -1);
    $display("seq N=2 holds@2,4: steps=%0d done@%0d", n_steps(), done_cyc());
    chk("hold_sel2", int'(tr_sel[2]), 3);
    chk("hold_sel4", int'(tr_sel[4]), 3);
    chk("hold_steps", n_steps(), 3);
    chk("hold_done", done_cyc(), 7);

    run_seq(0, 32'h8, 32'h0, -1);
    $display("seq N=0 hold@done: done@%0d", done_cyc());
    chk("hold_cout_done", done_cyc(), 3);
    chk("hold_cout_idle", int'(tr_busy[4]), 0);

    run_seq(5, 32'h0, 32'h8, -1);
    $display("seq N=5 abort@3: steps=%0d done@%0d", n_steps(), done_cyc());
    chk("abort_step3", int'(tr_step[3]), 0);
    chk("abort_sel3", int'(tr_sel[3]), 3);
    chk("abort_idle4", int'(tr_busy[4]), 0);
    chk("abort_nodone", done_cyc(), -1);

    run_seq(5, 32'h0, 32'h1, -1);
    $display("seq N=5 abort@0: steps=%0d busy1=%0d", n_steps(), tr_busy[1]);
    chk("abort_start_busy", int'(tr_busy[1]), 0);
    chk("abort_start_steps", n_steps(), 0);

    run_seq(6, 32'h0, 32'h0, 3);
    $display("seq N=6 restart@3: steps=%0d done@%0d", n_steps(), done_cyc());
    chk("restart_steps", n_steps(), 7);
    chk("restart_done", done_cyc(), 9);
    chk("restart_d", int'(tr_d[5]), 6);

    // asynchronous reset in the middle of RUN
    @(posedge CLK); #1 START = 1; COUNT = 4'd9;
    repeat (4) begin @(posedge CLK); #1 START = 0; end
    #2 RESET = 1;
    #1;
    $display("reset mid-run: busy=%0d sel=%0d d=%0d", BUSY, UCR_SEL, UCR_D);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_step", int'(STEP), 0);
    chk("arst_sel", int'(UCR_SEL), 3);
    chk("arst_cin", int'(UCR_CIN), 0);
    chk("arst_d", int'(UCR_D), 0);
    @(negedge CLK);
    @(posedge CLK); #1 RESET = 0;

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      START    = ($urandom % 4) == 0;
      COUNT    = 4'($urandom);
      HOLD_REQ = ($urandom % 4) == 0;
      ABORT    = ($urandom % 40) == 0;
      if (START && !BUSY && !ABORT)
        $display("random start N=%0d at %0t", COUNT, $time);
    end
    @(posedge CLK); #1;
    START = 0; HOLD_REQ = 0; ABORT = 0;
    repeat (25) @(posedge CLK);
    @(negedge CLK);
    chk("final_idle", int'(BUSY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
